// File: rtl/div_sched_pkg.sv
// div_sched_pkg: shared state enum, rate-select constants and the rate-to-exponent lookup.
package div_sched_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, STEP} state_e;
  localparam int SEL_W = 3;
  localparam logic [SEL_W-1:0] SEL_MAX = 3'd4;
  function automatic logic [7:0] sel_exp(input logic [SEL_W-1:0] s, input int e0, input int e1,
                                         input int e2, input int e3, input int e4);
    return s == 3'd0 ? 8'(e0) : s == 3'd1 ? 8'(e1) : s == 3'd2 ? 8'(e2) : s == 3'd3 ? 8'(e3) : 8'(e4);
  endfunction
endpackage

// File: rtl/div_prescaler.sv
// div_prescaler: period counter; counts while en, held at 0 while clr, wraps at 2**exp-1.
// Ports: clk, reset (sync, active-high), clr, en, exp (log2 of period), wrap (boundary this cycle).
module div_prescaler #(
  parameter int CNT_W = 28
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] exp,
  output logic       wrap
);
  logic [CNT_W-1:0] cnt_q, last;
  // An exponent equal to CNT_W overflows the shift to 0, and the subtraction then yields all ones.
  assign last = (CNT_W'(1) << exp) - CNT_W'(1);
  assign wrap = en && cnt_q == last;
  always_ff @(posedge clk)
    cnt_q <= (reset || clr || wrap) ? '0 : cnt_q + CNT_W'(en);
endmodule

// File: rtl/div_sched.sv
// div_sched: single-clock tick scheduler with run/stop/step and glitch-free rate switching.
// Ports: clk, reset (sync, active-high), run, step, sel_load, sel -> tick, tick_cnt, cur_sel,
// busy, sel_err, clk_out. Define DIV_SCHED_CLKOUT_EN to build the clk_out toggle register.
module div_sched
  import div_sched_pkg::*;
#(
  parameter int CNT_W = 28,
  parameter int EXP0  = 15,
  parameter int EXP1  = 21,
  parameter int EXP2  = 26,
  parameter int EXP3  = 27,
  parameter int EXP4  = 28
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             step,
  input  logic             sel_load,
  input  logic [SEL_W-1:0] sel,
  output logic             tick,
  output logic [7:0]       tick_cnt,
  output logic [SEL_W-1:0] cur_sel,
  output logic             busy,
  output logic             sel_err,
  output logic             clk_out
);
  state_e state_q, state_d;
  logic [SEL_W-1:0] cur_q, cur_d, pend_q, pend_d;
  logic pend_v_q, pend_v_d, tick_q, err_q, wrap, load_ok, apply;
  logic [7:0] tcnt_q;
  div_prescaler #(.CNT_W(CNT_W)) u_pre (
    .clk  (clk),
    .reset(reset),
    .clr  (state_q == IDLE),
    .en   (state_q != IDLE),
    .exp  (sel_exp(cur_q, EXP0, EXP1, EXP2, EXP3, EXP4)),
    .wrap (wrap)
  );
  assign load_ok = sel_load && sel <= SEL_MAX;
  // Rate changes only land where no period is in flight: in IDLE or on a boundary edge.
  // A load in that same cycle bypasses the pending latch so it governs the next period.
  assign apply = wrap || state_q == IDLE;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = run ? RUN : step ? STEP : IDLE;
      RUN:     state_d = run ? RUN : DRAIN;
      DRAIN:   state_d = run ? RUN : wrap ? IDLE : DRAIN;
      STEP:    state_d = wrap ? IDLE : STEP;
      default: state_d = IDLE;
    endcase
    cur_d    = apply ? (load_ok ? sel : pend_v_q ? pend_q : cur_q) : cur_q;
    pend_d   = load_ok ? sel : pend_q;
    pend_v_d = !apply && (load_ok || pend_v_q);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cur_q    <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      tick_q   <= 1'b0;
      tcnt_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      tick_q   <= wrap;
      tcnt_q   <= tcnt_q + {7'd0, wrap};
      err_q    <= sel_load && !(sel <= SEL_MAX);
    end
  end
  assign tick     = tick_q;
  assign tick_cnt = tcnt_q;
  assign cur_sel  = cur_q;
  assign busy     = state_q != IDLE;
  assign sel_err  = err_q;
`ifdef DIV_SCHED_CLKOUT_EN
  logic clk_q;
  always_ff @(posedge clk)
    clk_q <= reset ? 1'b0 : clk_q ^ wrap;
  assign clk_out = clk_q;
`else
  assign clk_out = 1'b0;
`endif
endmodule

// File: tb/tb_div_sched.sv
// tb_div_sched: directed stimulus with a tick scoreboard checked by an independent monitor.
module tb_div_sched;
  logic clk = 1'b0, reset, run, step, sel_load, tick, busy, sel_err, clk_out;
  logic [2:0] sel, cur_sel;
  logic [7:0] tick_cnt;
  int cyc = 0, checks = 0, errors = 0, exp_tc = 0, tog = 0, t;
  typedef struct {int at; int cnt; int sel; int clk;} exp_t;
  exp_t q[$];
`ifdef DIV_SCHED_CLKOUT_EN
  localparam bit CLK_EN = 1'b1;
`else
  localparam bit CLK_EN = 1'b0;
`endif
  div_sched #(.CNT_W(8), .EXP0(2), .EXP1(3), .EXP2(4), .EXP3(5), .EXP4(6)) dut (
    .clk(clk), .reset(reset), .run(run), .step(step), .sel_load(sel_load), .sel(sel),
    .tick(tick), .tick_cnt(tick_cnt), .cur_sel(cur_sel), .busy(busy), .sel_err(sel_err),
    .clk_out(clk_out)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, act, exp, cyc);
    end
  endtask
  task automatic push(input int at, input int s);
    exp_tc = (exp_tc + 1) % 256;
    tog ^= 1;
    q.push_back('{at, exp_tc, s, tog});
  endtask
  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (tick === 1'b1) begin
      if (q.size() == 0) chk("unexpected_tick", 1, 0);
      else begin
        e = q.pop_front();
        chk("tick_cycle", cyc, e.at);
        chk("tick_cnt", int'(tick_cnt), e.cnt);
        chk("tick_cur_sel", int'(cur_sel), e.sel);
        chk("tick_clk_out", int'(clk_out), CLK_EN ? e.clk : 0);
      end
    end else if (q.size() != 0 && cyc >= q[0].at) begin
      e = q.pop_front();
      chk("missed_tick_at", cyc, e.at + 1000000);
    end
  end
  initial begin
    reset = 1; run = 0; step = 0; sel_load = 0; sel = 0;
    repeat (2) @(negedge clk);
    reset = 0;
    @(negedge clk);
    chk("rst_tick", tick, 0); chk("rst_tick_cnt", tick_cnt, 0); chk("rst_cur_sel", cur_sel, 0);
    chk("rst_busy", busy, 0); chk("rst_sel_err", sel_err, 0); chk("rst_clk_out", clk_out, 0);
    t = cyc + 1; run = 1;
    for (int k = 1; k <= 3; k++) push(t + 4 * k, 0);
    @(negedge clk); chk("run_busy", busy, 1);
    wait_cyc(t + 13); sel_load = 1; sel = 3; push(t + 16, 3); push(t + 48, 3);
    @(negedge clk); sel_load = 0;
    wait_cyc(t + 15); chk("sel_not_yet", cur_sel, 0);
    wait_cyc(t + 16); chk("sel_switch", cur_sel, 3);
    wait_cyc(t + 49); sel_load = 1; sel = 1; push(t + 80, 1);
    @(negedge clk); sel_load = 0;
    wait_cyc(t + 81); run = 0; push(t + 88, 1);
    wait_cyc(t + 87); chk("drain_busy", busy, 1);
    wait_cyc(t + 89); chk("drain_idle", busy, 0);
    wait_cyc(t + 90); t = cyc + 1; run = 1; push(t + 8, 1);
    wait_cyc(t + 10); run = 0;
    wait_cyc(t + 12); run = 1; push(t + 16, 1); push(t + 24, 1);
    wait_cyc(t + 13); chk("rerun_busy", busy, 1);
    wait_cyc(t + 25); run = 0; push(t + 32, 1);
    wait_cyc(t + 33); chk("rerun_idle", busy, 0);
    @(negedge clk); sel_load = 1; sel = 2;
    @(negedge clk); sel_load = 0; chk("idle_sel", cur_sel, 2);
    t = cyc + 1; step = 1; push(t + 16, 2);
    @(negedge clk); step = 0; chk("step_busy", busy, 1);
    wait_cyc(t + 5); step = 1;
    @(negedge clk); step = 0;
    wait_cyc(t + 15); chk("step_busy_end", busy, 1);
    wait_cyc(t + 16); chk("step_done", busy, 0);
    wait_cyc(t + 40);
    t = cyc + 1; run = 1; push(t + 16, 2);
    @(negedge clk); run = 0;
    wait_cyc(t + 10); chk("rt_busy", busy, 1);
    wait_cyc(t + 17); chk("rt_idle", busy, 0);
    @(negedge clk); sel_load = 1; sel = 6;
    @(negedge clk); sel_load = 0; chk("sel_err_pulse", sel_err, 1); chk("sel_err_cur", cur_sel, 2);
    @(negedge clk); chk("sel_err_clear", sel_err, 0);
    sel_load = 1; sel = 4;
    @(negedge clk); sel_load = 0; chk("sel4", cur_sel, 4);
    t = cyc + 1; run = 1;
    wait_cyc(t + 30); reset = 1; run = 0;
    @(negedge clk);
    chk("mid_rst_tick", tick, 0); chk("mid_rst_tick_cnt", tick_cnt, 0);
    chk("mid_rst_cur_sel", cur_sel, 0); chk("mid_rst_busy", busy, 0);
    chk("mid_rst_sel_err", sel_err, 0); chk("mid_rst_clk_out", clk_out, 0);
    reset = 0; exp_tc = 0; tog = 0;
    wait_cyc(t + 120);
    t = cyc + 1; run = 1;
    for (int k = 1; k <= 300; k++) push(t + 4 * k, 0);
    wait_cyc(t + 1201); run = 0; chk("wrap_tick_cnt", tick_cnt, 44); push(t + 1204, 0);
    wait_cyc(t + 1210);
    chk("scoreboard_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/div_sched.md
# div_sched

Tick scheduler and controller for the slow-clock divider chain. Replaces the chain's ripple-clocked stages with single-clock operation. A programmable prescaler emits one-cycle `tick` enables at one of five selectable power-of-two rates. The block sequences the divider: run, stop, single-step and glitch-free rate switching, all from one system clock. Downstream logic uses `tick` as a clock enable instead of a derived clock.

## Interface
- `CNT_W`, 28: prescaler counter width; must satisfy `CNT_W >= max(EXPn)`.
- `EXP0`, 15: log2 of the divide ratio for `sel`=0.
- `EXP1`, 21: log2 of the divide ratio for `sel`=1.
- `EXP2`, 26: log2 of the divide ratio for `sel`=2.
- `EXP3`, 27: log2 of the divide ratio for `sel`=3.
- `EXP4`, 28: log2 of the divide ratio for `sel`=4.
- `clk` in 1: system clock, the only clock.
- `reset` in 1: synchronous, active-high reset.
- `run` in 1: level; request continuous ticking.
- `step` in 1: pulse; request exactly one tick period while idle.
- `sel_load` in 1: pulse; latch `sel` as the pending rate.
- `sel` in 3: rate index 0..4; values 5..7 are invalid.
- `tick` out 1: registered one-cycle pulse, once per period.
- `tick_cnt` out 8: wrapping count of emitted ticks.
- `cur_sel` out 3: rate index currently in effect.
- `busy` out 1: high in every state except IDLE.
- `sel_err` out 1: one-cycle pulse when `sel_load` carries an invalid `sel`.
- `clk_out` out 1: 50% square wave, toggled on each tick (see Configuration).

## Operation
- Period `L = 2**EXP[cur_sel]`. Counter `cnt` has `CNT_W` bits.
- States:
  - IDLE: `cnt` held at 0.
  - RUN
  - DRAIN
  - STEP
- Transitions:
  - IDLE→RUN when `run`=1.
  - IDLE→STEP when `step`=1 and `run`=0. `run` wins if both are high.
  - RUN→DRAIN when `run`=0.
  - DRAIN→RUN when `run` returns to 1 before the boundary; the period is not restarted.
  - DRAIN→IDLE at the boundary.
  - STEP→IDLE at the boundary.
- `step` is ignored outside IDLE. `run` is ignored in STEP.
- Counting states (RUN, DRAIN, STEP): `cnt` increments every cycle.
- Boundary (`cnt == L-1`):
  - `cnt` is set to 0 and `tick` is set to 1.
  - `tick_cnt` increments, wrapping 255→0.
  - Pending rate, if valid, moves to `cur_sel`.
- Periods are never truncated or stretched; a rate change affects only whole periods.
- `sel_load` with `sel` ≤ 4:
  - Sets the pending rate; the last load before a boundary wins.
  - In IDLE the new rate applies to `cur_sel` on the next edge.
  - A load in the boundary cycle takes effect for the immediately following period.
- `sel_load` with `sel` ≥ 5: pulses `sel_err` the next cycle; pending and current rates are unchanged.

## Timing
- Reset values:
  - state = IDLE, `cnt` = 0
  - `tick` = 0, `tick_cnt` = 0, `cur_sel` = 0, `busy` = 0, `sel_err` = 0, `clk_out` = 0
  - no pending rate
- Reset mid-period aborts immediately. No tick is emitted, and any pending rate is discarded.
- First tick latency: if `run` is sampled at edge t0, `tick` is high during the cycle after edge t0+L. Each following tick comes exactly L cycles later.
- STEP: exactly one tick, L cycles after `step` is sampled. `busy` is high for L cycles, then drops on the edge that raises `tick`.
- `busy` and `cur_sel` are registered and update on the same edge as the state change.
- The IDLE→RUN→IDLE round trip with `run` high for one cycle still emits one full-period tick.

## Configuration
- `DIV_SCHED_CLKOUT_EN` defined:
  - `clk_out` toggles on every boundary edge, giving period 2L and 50% duty.
  - `clk_out` holds its level in IDLE.
  - Reset returns `clk_out` to 0.
- `DIV_SCHED_CLKOUT_EN` undefined: `clk_out` is tied to 0 and its toggle register is not built.

## Structure
- Package `div_sched_pkg` holds:
  - the state enum (`IDLE`, `RUN`, `DRAIN`, `STEP`)
  - the `SEL_W`=3 constant
  - the `SEL_MAX`=4 constant
  - a function mapping `sel` to exponent, given the EXP parameters
- One sub-module, `div_prescaler`:
  - contains the `cnt` register, a clear/enable interface and the `L-1` compare
  - outputs `wrap`
  - the FSM, rate latch and tick counter stay in `div_sched`.

## Test plan
Bench overrides: `EXP0..4` = 2,3,4,5,6; `CNT_W` = 8.
- Reset, then `run`=1 at t0 with `cur_sel`=0 → ticks at cycles t0+4, t0+8, t0+12; `tick_cnt` = 1, 2, 3; `busy`=1.
- While running at `sel`=0, `sel_load` with `sel`=3 in mid-period → the current 4-cycle period completes, then ticks are 32 apart; `cur_sel`=3 from the boundary edge on.
- `run` drops 2 cycles into a `sel`=1 period → DRAIN, tick at the 8-cycle boundary, then IDLE with `busy`=0. `run` reasserted during DRAIN → the tick cadence is unbroken.
- In IDLE, `sel_load` `sel`=2, then `step` → exactly one tick 16 cycles later, then IDLE. A second `step` during STEP is ignored.
- `sel_load` with `sel`=6 → `sel_err` pulses for one cycle; `cur_sel` is unchanged.
- Reset asserted mid-period of RUN at `sel`=4 → next cycle all outputs are at reset values and no tick occurs. 300 ticks at `sel`=0 → `tick_cnt`=44 after wrap. With `DIV_SCHED_CLKOUT_EN` defined, `clk_out` period is 8 cycles.
